// File: rtl/mdu_sequencer.sv
// mdu_sequencer: E-stage multiply/divide controller with fixed-latency busy window and HI/LO commit.
module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        req,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [63:0] res_q, res_d;
  logic        keep_q;
  logic        sgn, acc;
  logic [63:0] a64, b64;
  logic [31:0] ua, ub, uq, ur, q, r;
  // Signed divide runs on magnitudes so the -2^31/-1 corner stays exact.
  always_comb begin
    sgn = op == 3'd1 || op == 3'd3;
    a64 = {{32{sgn & rs[31]}}, rs};
    b64 = {{32{sgn & rt[31]}}, rt};
    ua  = sgn && rs[31] ? -rs : rs;
    ub  = sgn && rt[31] ? -rt : rt;
    uq  = ub == '0 ? '0 : ua / ub;
    ur  = ub == '0 ? '0 : ua % ub;
    q   = sgn && (rs[31] ^ rt[31]) ? -uq : uq;
    r   = sgn && rs[31] ? -ur : ur;
    res_d = op <= 3'd2 ? a64 * b64 : {r, q};
    acc = start && !req && state_q == IDLE && op != 3'd0 && op != 3'd7;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      keep_q  <= 1'b0;
      busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else if (acc) begin
      if (op == 3'd5) hi <= rs;
      else if (op == 3'd6) lo <= rs;
      else begin
        res_q   <= res_d;
        keep_q  <= op >= 3'd3 && rt == '0;
        cnt_q   <= op <= 3'd2 ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
        state_q <= RUN;
        busy    <= 1'b1;
      end
    end else if (state_q == RUN) begin
      cnt_q <= cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_q <= IDLE;
        busy    <= 1'b0;
        if (!keep_q) {hi, lo} <= res_q;
      end
    end
  end
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed plus random stimulus against a cycle-level HI/LO/busy reference model.
module tb_mdu_sequencer;
  localparam int MC = 5;
  localparam int DC = 10;
  logic        clk = 1'b0;
  logic        reset, start, req;
  logic [2:0]  op;
  logic [31:0] rs, rt;
  logic        busy;
  logic [31:0] hi, lo;
  int          nvec = 0;
  int          nerr = 0;
  int          rem = 0;
  logic        pok = 1'b0;
  logic [31:0] mhi = '0, mlo = '0, phi = '0, plo = '0;

  mdu_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .req(req), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    longint sa, sb;
    longint unsigned xa, xb, p;
    sa = longint'($signed(rs));
    sb = longint'($signed(rt));
    xa = {32'h0, rs};
    xb = {32'h0, rt};
    if (reset) begin
      mhi = '0; mlo = '0; rem = 0; pok = 1'b0;
    end else if (rem > 0) begin
      rem--;
      if (rem == 0 && pok) begin mhi = phi; mlo = plo; end
    end else if (start && !req && op >= 3'd1 && op <= 3'd6) begin
      case (op)
        3'd1: begin p = longint'(sa * sb); {phi, plo} = p; pok = 1'b1; rem = MC; end
        3'd2: begin p = xa * xb; {phi, plo} = p; pok = 1'b1; rem = MC; end
        3'd3: begin
          pok = rt != 0; rem = DC;
          if (pok) begin plo = 32'(sa / sb); phi = 32'(sa % sb); end
        end
        3'd4: begin
          pok = rt != 0; rem = DC;
          if (pok) begin plo = 32'(xa / xb); phi = 32'(xa % xb); end
        end
        3'd5: mhi = rs;
        default: mlo = rs;
      endcase
    end
  endtask

  task automatic cyc(input logic s, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic rq, input logic rst);
    start = s; op = o; rs = a; rt = b; req = rq; reset = rst;
    @(posedge clk);
    model_edge();
    #1;
    chk("busy", {31'b0, busy}, {31'b0, rem > 0});
    chk("hi", hi, mhi);
    chk("lo", lo, mlo);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    cyc(1'b0, 3'd0, '0, '0, 1'b0, 1'b1);
    cyc(1'b0, 3'd0, '0, '0, 1'b0, 1'b1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    cyc(1'b1, 3'd1, 32'hFFFFFFFD, 32'd5, 1'b0, 1'b0);
    idle(MC);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFF1);
    cyc(1'b1, 3'd2, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0);
    idle(MC);
    chk("multu_hi", hi, 32'h00000001);
    chk("multu_lo", lo, 32'hFFFFFFFE);
    cyc(1'b1, 3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    idle(DC);
    chk("div_hi", hi, 32'hFFFFFFFF);
    chk("div_lo", lo, 32'hFFFFFFFD);
    cyc(1'b1, 3'd5, 32'h11, '0, 1'b0, 1'b0);
    cyc(1'b1, 3'd6, 32'h22, '0, 1'b0, 1'b0);
    cyc(1'b1, 3'd4, 32'd100, 32'd0, 1'b0, 1'b0);
    idle(DC);
    chk("dz_hi", hi, 32'h11);
    chk("dz_lo", lo, 32'h22);
    cyc(1'b1, 3'd1, 32'd7, 32'd9, 1'b1, 1'b0);
    chk("req_busy", {31'b0, busy}, 32'd0);
    chk("req_hi", hi, 32'h11);
    cyc(1'b1, 3'd2, 32'd7, 32'd9, 1'b0, 1'b0);
    cyc(1'b1, 3'd5, 32'hCAFEF00D, '0, 1'b0, 1'b0);
    chk("run_mthi", hi, 32'h11);
    idle(MC - 1);
    chk("run_commit_hi", hi, 32'd0);
    chk("run_commit_lo", lo, 32'd63);
    cyc(1'b1, 3'd3, 32'd1000, 32'd7, 1'b0, 1'b0);
    idle(2);
    cyc(1'b0, 3'd0, '0, '0, 1'b0, 1'b1);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_lo", lo, 32'd0);
    idle(DC);
    chk("abort_late", lo, 32'd0);
    cyc(1'b1, 3'd5, 32'hDEADBEEF, '0, 1'b0, 1'b0);
    chk("mthi", hi, 32'hDEADBEEF);
    cyc(1'b1, 3'd6, 32'h12345678, '0, 1'b0, 1'b0);
    chk("mtlo", lo, 32'h12345678);
    chk("mt_busy", {31'b0, busy}, 32'd0);
    cyc(1'b1, 3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    idle(DC);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'd0);
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, b;
      a = $urandom_range(3) == 0 ? $urandom_range(40) - 20 : $urandom;
      b = $urandom_range(5) == 0 ? 32'd0 : ($urandom_range(2) == 0 ? $urandom_range(20) - 10 : $urandom);
      cyc(1'($urandom_range(1)), 3'($urandom_range(7)), a, b,
          $urandom_range(4) == 0, $urandom_range(80) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multiply/divide unit controller in the E stage of the P7 pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo commands and latches the operands.
- Models the fixed multi-cycle latency with a counter and commits the results to HI/LO.
- Drives the busy signal that the stall logic combines with start to hold MDU instructions in D; exposes HI/LO for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- start  input  1  E-stage MDU command valid this cycle
- op  input  3  command: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- rs  input  32  forwarded operand A (dividend / multiplicand / mthi-mtlo data)
- rt  input  32  forwarded operand B (divisor / multiplier)
- req  input  1  exception/interrupt request from M stage; suppresses the E-stage command this cycle
- busy  output  1  operation in progress
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Clocking and reset: single clock; reset is synchronous and active-high.
- Reset values: busy=0, hi=0, lo=0, state IDLE, counter=0, pending result = 0.
- States: IDLE and RUN.
- Command acceptance: a command is accepted in cycle C when start=1, req=0, state=IDLE, and op is 1..6.
  - Any other combination leaves the state unchanged.
  - start while in RUN is ignored; HI/LO and the counter are unaffected.
- mult/multu/div/divu (op 1..4) at the edge ending cycle C:
  - Compute the 64-bit pending result from rs/rt.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN; busy=1 from cycle C+1.
- RUN:
  - Counter decrements each cycle; busy=1 for exactly N cycles (C+1..C+N).
  - At the edge ending cycle C+N, commit {hi,lo} from the pending result and return to IDLE.
  - busy=0 and the new hi/lo are visible in cycle C+N+1.
- Arithmetic:
  - mult: signed 32x32 to 64; hi=result[63:32], lo=result[31:0].
  - multu: same as mult, unsigned.
  - div: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Divide by zero (rt=0, op 3/4): runs the full DIV_CYCLES with busy high; hi and lo keep their prior values at commit.
- mthi/mtlo (op 5/6) when accepted:
  - Write rs to hi or lo at the edge ending cycle C; visible in C+1.
  - busy stays 0; no RUN entry.
- req=1 with start=1: the command is fully suppressed (no busy, no HI/LO write). This keeps the instruction after the exception victim from altering HI/LO.
- req during RUN: the operation continues and commits normally.
- Reset during RUN: aborts immediately; next cycle busy=0, hi=lo=0, pending result discarded.
- hi/lo are registered outputs; no combinational path from rs/rt to hi/lo.
- No combinational path from start to busy; busy is registered, and the stall logic ORs start itself.

Test Plan:
- mult, rs=0xFFFFFFFD (-3), rt=5 -> busy high exactly cycles C+1..C+5; in C+6 hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- multu, rs=0xFFFFFFFF, rt=2 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE. Then div, rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFD.
- divu, rs=100, rt=0, with hi=0x11, lo=0x22 preloaded via mthi/mtlo -> busy 10 cycles; hi=0x11, lo=0x22 unchanged.
- start=1 with op=1 and req=1 simultaneously -> busy stays 0, hi/lo unchanged. Then start during RUN with op=5 -> ignored, hi unchanged until commit.
- Reset asserted in the 3rd busy cycle of a div -> next cycle busy=0, hi=lo=0; no late commit in the following 10 cycles.
- mthi rs=0xDEADBEEF then mtlo rs=0x12345678 on consecutive cycles -> hi=0xDEADBEEF in C+1, lo=0x12345678 in C+2, busy never asserted.
